// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and default parameters for run_ctrl
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int DEF_NUM_CORES    = 1;
    localparam int DEF_DATA_W       = 32;
    localparam int DEF_CNT_W        = 16;
    localparam int DEF_RST_CYCLES   = 2;
    localparam int DEF_MAX_CYCLES   = 34;
    localparam int DEF_DRAIN_CYCLES = 5;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/run_ctrl_timer.sv
// rtl/run_ctrl_timer.sv - loadable down-counter with zero flag, shared by RESET and DRAIN
module cycle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // Free-runs down to zero and parks there until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - run sequencer: core reset, budgeted run, drain and signature check
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int NUM_CORES    = DEF_NUM_CORES,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int RST_CYCLES   = DEF_RST_CYCLES,
    parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CORES-1:0]        halt,
    input  logic [NUM_CORES*DATA_W-1:0] result,
    input  logic [DATA_W-1:0]           expected,
    output logic                        core_rst,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic [NUM_CORES-1:0]        halted,
    output logic [NUM_CORES-1:0]        fail_mask,
    output logic [CNT_W-1:0]            cycle_count
);

    localparam int TW = $clog2(max2(RST_CYCLES, DRAIN_CYCLES) + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_CYCLES - 1);

    state_t               state;
    logic                 tmr_load;
    logic [TW-1:0]        tmr_value;
    logic                 tmr_zero;
    logic [NUM_CORES-1:0] halted_next;
    logic [NUM_CORES-1:0] mismatch;

    assign halted_next = halted | halt;

    always_comb begin
        mismatch = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            mismatch[i] = (result[i*DATA_W +: DATA_W] != expected);
        end
    end

    // Timer is loaded with length-1 so the phase spans exactly `length` cycles.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (!rst) begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(RST_CYCLES - 1);
                end
                S_RUN: if (&halted_next) begin
                    tmr_load  = 1'b1;
                    tmr_value = TW'(DRAIN_CYCLES - 1);
                end
                default: ;
            endcase
        end
    end

    cycle_timer #(.W(TW)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            halted      <= '0;
            fail_mask   <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: if (start) begin
                    state       <= S_RESET;
                    core_rst    <= 1'b1;
                    busy        <= 1'b1;
                    done        <= 1'b0;
                    pass        <= 1'b0;
                    timeout     <= 1'b0;
                    halted      <= '0;
                    fail_mask   <= '0;
                    cycle_count <= '0;
                end
                S_RESET: if (tmr_zero) begin
                    state    <= S_RUN;
                    core_rst <= 1'b0;
                end
                S_RUN: begin
                    halted <= halted_next;
                    // A final halt beats an expiring budget in the same cycle.
                    if (&halted_next) begin
                        state <= S_DRAIN;
                    end else if (cycle_count == LAST_CNT) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        timeout <= 1'b1;
                    end else if (cycle_count != '1) begin
                        cycle_count <= cycle_count + CNT_W'(1);
                    end
                end
                S_DRAIN: if (tmr_zero) begin
                    state     <= S_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    fail_mask <= mismatch;
                    pass      <= ~|mismatch;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
